// File: rtl/vga_if.sv
// vga_if: pattern-control inputs and timed video outputs of the VGA timing generator.
interface vga_if #(
    parameter int CW = 3,
    parameter int XW = 10,
    parameter int YW = 9
);
    logic [2:0]      mode;
    logic [3*CW-1:0] color;
    logic            hsync;
    logic            vsync;
    logic            de;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            line_start;
    logic            frame_start;
    logic [3*CW-1:0] rgb;
    modport master (input mode, color, output hsync, vsync, de, x, y, line_start, frame_start, rgb);
    modport slave (output mode, color, input hsync, vsync, de, x, y, line_start, frame_start, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing and test-pattern generator, all outputs registered one cycle after the counters.
// Define VGA_BORDER_EN to force a white one-pixel border around the active area.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 3,
    parameter int BOX_W    = 200,
    parameter int BOX_H    = 200,
    parameter int CHK_LOG2 = 5
) (
    input logic   clk,
    input logic   rst,
    vga_if.master bus
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int PW = 3 * CW;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW = $clog2(BAR_W + 1);
    localparam logic [HW-1:0] H_SE   = HW'(H_SYNC);
    localparam logic [HW-1:0] H_PRE  = HW'(H_SYNC + H_BP - 1);
    localparam logic [HW-1:0] H_AS   = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_AE   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_SE   = VW'(V_SYNC);
    localparam logic [VW-1:0] V_AS   = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_AE   = VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [XW:0] BX0 = (XW+1)'((H_ACTIVE - BOX_W) / 2);
    localparam logic [XW:0] BX1 = (XW+1)'((H_ACTIVE + BOX_W) / 2);
    localparam logic [YW:0] BY0 = (YW+1)'((V_ACTIVE - BOX_H) / 2);
    localparam logic [YW:0] BY1 = (YW+1)'((V_ACTIVE + BOX_H) / 2);
    localparam logic [BW-1:0] BAR_END = BW'(BAR_W - 1);
    // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_LUT [8] = '{3'd7, 3'd6, 3'd3, 3'd2, 3'd5, 3'd4, 3'd1, 3'd0};

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [2:0]    mode_q;
    logic [PW-1:0] color_q;
    logic [2:0]    bar_idx;
    logic [BW-1:0] bar_pix;
    logic          de_c, fs_c, chk, in_box;
    logic [XW-1:0] x_c;
    logic [YW-1:0] y_c;
    logic [2:0]    bar_f;
    logic [PW-1:0] bar_rgb, pat, rgb_c;

    always_comb begin
        de_c = h_cnt >= H_AS && h_cnt < H_AE && v_cnt >= V_AS && v_cnt < V_AE;
        fs_c = h_cnt == '0 && v_cnt == '0;
        x_c = XW'(h_cnt - H_AS);
        y_c = YW'(v_cnt - V_AS);
        bar_f = BAR_LUT[bar_idx];
        bar_rgb = {{CW{bar_f[2]}}, {CW{bar_f[1]}}, {CW{bar_f[0]}}};
        chk = x_c[CHK_LOG2] ^ y_c[CHK_LOG2];
        in_box = {1'b0, x_c} >= BX0 && {1'b0, x_c} < BX1 && {1'b0, y_c} >= BY0 && {1'b0, y_c} < BY1;
        pat = mode_q == 3'd1 ? color_q :
              mode_q == 3'd2 ? bar_rgb :
              mode_q == 3'd3 ? {PW{chk}} :
              (mode_q == 3'd4 && in_box) ? color_q : '0;
`ifdef VGA_BORDER_EN
        rgb_c = (x_c == '0 || x_c == XW'(H_ACTIVE - 1) || y_c == '0 || y_c == YW'(V_ACTIVE - 1)) ? '1 : pat;
`else
        rgb_c = pat;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            mode_q          <= '0;
            color_q         <= '0;
            bar_idx         <= '0;
            bar_pix         <= '0;
            bus.hsync       <= ~HS_POL;
            bus.vsync       <= ~VS_POL;
            bus.de          <= 1'b0;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.rgb         <= '0;
        end else begin
            h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + 1'b1;
            if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
            if (fs_c) begin
                mode_q  <= bus.mode;
                color_q <= bus.color;
            end
            // bar position tracks the pixel under h_cnt, rearmed just before each active line
            bar_pix <= (h_cnt == H_PRE || bar_pix == BAR_END) ? '0 : bar_pix + 1'b1;
            if (h_cnt == H_PRE) bar_idx <= '0;
            else if (bar_pix == BAR_END) bar_idx <= bar_idx + 1'b1;
            bus.hsync       <= h_cnt < H_SE ? HS_POL : ~HS_POL;
            bus.vsync       <= v_cnt < V_SE ? VS_POL : ~VS_POL;
            bus.de          <= de_c;
            bus.x           <= de_c ? x_c : '0;
            bus.y           <= de_c ? y_c : '0;
            bus.line_start  <= de_c && h_cnt == H_AS;
            bus.frame_start <= fs_c;
            bus.rgb         <= de_c ? rgb_c : '0;
        end
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing and test-pattern generator; successor to the fixed 640x480 green-box generator.
- Produces hsync/vsync, data-enable, pixel coordinates and patterned RGB, all aligned on the same registered cycle.
- Sits between the pixel-clock domain and the DAC/resistor-ladder output pins. Downstream frame sources use x/y/de/frame_start to stay in lock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync pulse width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync pulse width, in lines
- V_BP, 33, vertical back porch, in lines
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- CW, 3, bits per colour channel; rgb is {R,G,B}, each CW bits
- BOX_W, 200, width of the box pattern
- BOX_H, 200, height of the box pattern
- CHK_LOG2, 5, checker square side is 2^CHK_LOG2 pixels

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset: synchronous, active-high
- mode  in  3  pattern select; sampled at frame start only
- color  in  3*CW  foreground colour for solid and box modes; sampled with mode
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  high during the active area
- x  out  clog2(H_ACTIVE)  active pixel column; 0 when de=0
- y  out  clog2(V_ACTIVE)  active line; 0 when de=0
- line_start  out  1  one-cycle pulse on the first active pixel of each active line
- frame_start  out  1  one-cycle pulse when h_cnt=0 and v_cnt=0
- rgb  out  3*CW  pixel data; all zero when de=0

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. V_TOTAL is defined the same way from the V_ parameters.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments only when h_cnt wraps, and itself wraps at V_TOTAL-1.
- Region order on each axis:
  - sync: [0, SYNC)
  - back porch: [SYNC, SYNC+BP)
  - active: [SYNC+BP, SYNC+BP+ACTIVE)
  - front porch: the rest of the line or frame
- The sync asserted level is the POL value; the idle level is its inverse. vsync is derived from v_cnt only; hsync is derived from h_cnt only.
- Latency:
  - All outputs are registered from the current (h_cnt, v_cnt) and appear exactly 1 cycle later.
  - hsync, vsync, de, x, y and rgb always refer to the same pixel. No output is delayed by a different amount from any other.
- Reset:
  - Counters go to 0.
  - hsync and vsync go to their idle levels.
  - de, x, y, line_start, frame_start and rgb go to 0.
  - The mode shadow goes to 0 and the colour shadow goes to 0.
  - Reset asserted mid-frame restarts the frame. The first cycle after reset is released is h_cnt=0, v_cnt=0, and frame_start is output on the following cycle.
- Mode shadow:
  - mode and color are captured only on the cycle where h_cnt=0 and v_cnt=0.
  - Changes during a frame have no effect until the next frame.
- Patterns (mode shadow), evaluated only when de=1:
  - 0: black.
  - 1: solid colour.
  - 2: eight vertical bars, each H_ACTIVE/8 wide, left to right: white, yellow, cyan, green, magenta, red, blue, black. The bar index is kept in an incremental counter; no divider is used. H_ACTIVE must be a multiple of 8.
  - 3: checkerboard. White where x[CHK_LOG2] XOR y[CHK_LOG2] is 1, black otherwise.
  - 4: box pattern. Colour where x is in [(H_ACTIVE-BOX_W)/2, (H_ACTIVE+BOX_W)/2) and y is in [(V_ACTIVE-BOX_H)/2, (V_ACTIVE+BOX_H)/2); black elsewhere.
  - 5-7: treated as mode 0.
- Colour constants: white = all ones; black = all zeros; the other bar colours are full-scale combinations of the three channels.
- Counter widths are clog2(TOTAL). The comparisons never wrap.

Optional Feature:
- Macro: VGA_BORDER_EN.
- When defined: any pixel with x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1 outputs white, overriding every mode including 0. Latency and alignment are unchanged.
- When undefined: no border logic; rgb comes only from the pattern.

Test Plan:
- Defaults, mode=0, run 2 frames:
  - the hsync period is 800 clk, low for 96 clk;
  - the vsync period is 420000 clk, low for 1600 clk;
  - de is high for 640 clk per line on 480 lines.
- Defaults, from reset release:
  - the first de rises 1+(35*800)+144 cycles after release, with x=0 and y=0 and line_start=1;
  - frame_start pulses exactly once every 420000 cycles.
- mode=2, frame 2: rgb changes at x=80, 160, ..., 560. Bar 0 is all ones, bar 7 is all zeros, and rgb=0 in blanking.
- mode=4, color=9'o070:
  - rgb=9'o070 at (220,140) and at (419,339);
  - rgb=0 at (219,140) and at (420,339).
- Change mode 1->3 in the middle of a frame: output stays solid until the next frame_start, then the checkerboard starts, with a square edge at x=32.
- Assert rst for 1 cycle at v_cnt=200: all outputs are at their reset values the next cycle, and the counters restart from 0, 0. With VGA_BORDER_EN and mode=0, only the border pixels are white.
